// File: rtl/fpr_file_dp_if.sv
// Bus bundle for the FP register file.
// Covers the decode-side read/claim signals, the writeback-side write signals,
// and the status returned by the register file. The register file uses the
// slave modport; the decode/writeback side uses the master modport.
interface fpr_file_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Read ports
  logic [ADDR_W-1:0]   rs_addr;
  logic [ADDR_W-1:0]   rt_addr;
  logic                rd_dbl;
  logic [2*DATA_W-1:0] busA;
  logic [2*DATA_W-1:0] busB;
  logic                busyA;
  logic                busyB;

  // Write port
  logic                regWr;
  logic                wr_dbl;
  logic [ADDR_W-1:0]   Rw;
  logic [2*DATA_W-1:0] busW;

  // Scoreboard claims
  logic                claim_en;
  logic [ADDR_W-1:0]   claim_addr;
  logic                claim_dbl;
  logic                claim_conflict;

  // Status
  logic                pair_err;

  modport master (
    output rs_addr, rt_addr, rd_dbl,
    output regWr, wr_dbl, Rw, busW,
    output claim_en, claim_addr, claim_dbl,
    input  busA, busB, busyA, busyB, claim_conflict, pair_err
  );

  modport slave (
    input  rs_addr, rt_addr, rd_dbl,
    input  regWr, wr_dbl, Rw, busW,
    input  claim_en, claim_addr, claim_dbl,
    output busA, busB, busyA, busyB, claim_conflict, pair_err
  );
endinterface

// File: rtl/fpr_file_dp.sv
// FP register file with double-precision pair access and a busy scoreboard.
// Two combinational read ports and one write port, each carrying a register
// pair {reg[n], reg[n+1]} on 2*DATA_W bits. A busy bit per register tracks
// in-flight multi-cycle FP results. A claim that lands on a register that is
// already busy raises a one-cycle claim_conflict pulse. Any pair access with
// an odd address sets the sticky pair_err flag.
// Optional feature macro: FPR_BYPASS_EN. When defined, same-cycle write data
// is forwarded to the read ports for each half individually. When undefined,
// reads return the stored contents until the write edge.
module fpr_file_dp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input logic          clk,
  input logic          reset,
  fpr_file_dp_if.slave bus
);

`ifdef FPR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PAIR_LSB = ADDR_W'(1);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                claim_conflict_q;
  logic                pair_err_q;

  logic [ADDR_W-1:0]   rs_hi, rs_lo, rt_hi, rt_lo;
  logic [ADDR_W-1:0]   wr_hi, wr_lo, cl_hi, cl_lo;
  logic                rs_ok, rt_ok;
  logic                wr_hi_en, wr_lo_en, cl_hi_en, cl_lo_en;
  logic [DATA_W-1:0]   wr_hi_data, wr_lo_data;
  logic [DATA_W-1:0]   a_hi, a_lo, b_hi, b_lo;
  logic                a_busy, b_busy;
  logic                conflict_d, pair_err_d;

  // An address only selects a register when it is below NUM_REGS.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // Replace a read half with write data if the same register is written this cycle.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] cur,
    input logic              hi_en,
    input logic [ADDR_W-1:0] hi_idx,
    input logic [DATA_W-1:0] hi_data,
    input logic              lo_en,
    input logic [ADDR_W-1:0] lo_idx,
    input logic [DATA_W-1:0] lo_data
  );
    logic [DATA_W-1:0] r;
    r = cur;
    if (hi_en && idx == hi_idx) r = hi_data;
    if (lo_en && idx == lo_idx) r = lo_data;
    return r;
  endfunction

  // Decode addresses: pair accesses clear bit0, and the partner is bit0 set.
  always_comb begin
    rs_hi      = bus.rd_dbl ? (bus.rs_addr & ~PAIR_LSB) : bus.rs_addr;
    rs_lo      = bus.rs_addr | PAIR_LSB;
    rt_hi      = bus.rd_dbl ? (bus.rt_addr & ~PAIR_LSB) : bus.rt_addr;
    rt_lo      = bus.rt_addr | PAIR_LSB;
    wr_hi      = bus.wr_dbl ? (bus.Rw & ~PAIR_LSB) : bus.Rw;
    wr_lo      = bus.Rw | PAIR_LSB;
    cl_hi      = bus.claim_dbl ? (bus.claim_addr & ~PAIR_LSB) : bus.claim_addr;
    cl_lo      = bus.claim_addr | PAIR_LSB;
    rs_ok      = in_range(rs_hi);
    rt_ok      = in_range(rt_hi);
    wr_hi_en   = bus.regWr && in_range(wr_hi);
    wr_lo_en   = bus.regWr && bus.wr_dbl && in_range(wr_hi);
    cl_hi_en   = bus.claim_en && in_range(cl_hi);
    cl_lo_en   = bus.claim_en && bus.claim_dbl && in_range(cl_hi);
    wr_hi_data = bus.busW[2*DATA_W-1:DATA_W];
    wr_lo_data = bus.busW[DATA_W-1:0];
  end

  // Read port A: stored data and busy bits, with optional write forwarding per half.
  always_comb begin
    a_hi   = '0;
    a_lo   = '0;
    a_busy = 1'b0;
    if (rs_ok) begin
      a_hi   = regs[rs_hi];
      a_busy = busy[rs_hi];
      if (BYPASS)
        a_hi = fwd(rs_hi, a_hi, wr_hi_en, wr_hi, wr_hi_data, wr_lo_en, wr_lo, wr_lo_data);
      if (bus.rd_dbl) begin
        a_lo   = regs[rs_lo];
        a_busy = a_busy | busy[rs_lo];
        if (BYPASS)
          a_lo = fwd(rs_lo, a_lo, wr_hi_en, wr_hi, wr_hi_data, wr_lo_en, wr_lo, wr_lo_data);
      end
    end
  end

  // Read port B: same structure as port A.
  always_comb begin
    b_hi   = '0;
    b_lo   = '0;
    b_busy = 1'b0;
    if (rt_ok) begin
      b_hi   = regs[rt_hi];
      b_busy = busy[rt_hi];
      if (BYPASS)
        b_hi = fwd(rt_hi, b_hi, wr_hi_en, wr_hi, wr_hi_data, wr_lo_en, wr_lo, wr_lo_data);
      if (bus.rd_dbl) begin
        b_lo   = regs[rt_lo];
        b_busy = b_busy | busy[rt_lo];
        if (BYPASS)
          b_lo = fwd(rt_lo, b_lo, wr_hi_en, wr_hi, wr_hi_data, wr_lo_en, wr_lo, wr_lo_data);
      end
    end
  end

  // Detect a WAW claim hit and any odd address used for a pair access.
  always_comb begin
    conflict_d = (cl_hi_en && busy[cl_hi]) || (cl_lo_en && busy[cl_lo]);
    pair_err_d = (bus.rd_dbl && (bus.rs_addr[0] || bus.rt_addr[0]))
              || (bus.regWr && bus.wr_dbl && bus.Rw[0])
              || (bus.claim_en && bus.claim_dbl && bus.claim_addr[0]);
  end

  // Register storage: write one or both halves of the write bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_hi_en) regs[wr_hi] <= wr_hi_data;
      if (wr_lo_en) regs[wr_lo] <= wr_lo_data;
    end
  end

  // Scoreboard: a claim sets busy and takes priority over a write that clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((cl_hi_en && cl_hi == ADDR_W'(i)) || (cl_lo_en && cl_lo == ADDR_W'(i)))
          busy[i] <= 1'b1;
        else if ((wr_hi_en && wr_hi == ADDR_W'(i)) || (wr_lo_en && wr_lo == ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

  // Status flags: one-cycle conflict pulse and sticky pair error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      claim_conflict_q <= 1'b0;
      pair_err_q       <= 1'b0;
    end else begin
      claim_conflict_q <= conflict_d;
      pair_err_q       <= pair_err_q | pair_err_d;
    end
  end

  assign bus.busA           = {a_hi, a_lo};
  assign bus.busB           = {b_hi, b_lo};
  assign bus.busyA          = a_busy;
  assign bus.busyB          = b_busy;
  assign bus.claim_conflict = claim_conflict_q;
  assign bus.pair_err       = pair_err_q;

endmodule
